// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive front end: FSM encodings,
// frame length and default filter/watchdog settings.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } rx_state_e;

  localparam int FRAME_EDGES        = 11;
  localparam int DEF_FILTER_LEN     = 8;
  localparam int DEF_TIMEOUT_CYCLES = 200000;
  localparam int DEF_TO_W           = 18;

  // Odd parity holds when data bits and parity bit XOR to 1.
  function automatic logic parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// 2-FF synchroniser, FILTER_LEN-sample level filter and registered
// falling-edge strobe for one PS/2 line (used for ps2_c).
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic fall_edge_o
);

  logic [1:0]            sync_q, sync_d;
  logic [FILTER_LEN-1:0] shreg_q, shreg_d;
  logic                  level_q, level_d;
  logic                  fall_q, fall_d;

  always_comb begin
    sync_d  = {sync_q[0], line_i};
    shreg_d = {shreg_q[FILTER_LEN-2:0], sync_q[1]};
    level_d = level_q;
    if (shreg_d == '0) begin
      level_d = 1'b0;
    end else if (&shreg_d) begin
      level_d = 1'b1;
    end
    // Strobe is registered together with the level, so it lands FILTER_LEN+2 cycles after the pin.
    fall_d = level_q & ~level_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      shreg_q <= '1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      shreg_q <= shreg_d;
      level_q <= level_d;
      fall_q  <= fall_d;
    end
  end

  assign fall_edge_o = fall_q;

endmodule

// File: rtl/ps2_rx_frontend.sv
// PS/2 receive front end: filtered clock edges, 11-edge frame counter and
// device-to-host deserialiser. Optional idle watchdog: PS2_RX_TIMEOUT_EN.
module ps2_rx_frontend
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = DEF_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int TO_W           = DEF_TO_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_c,
  input  logic       ps2_d,
  input  logic       rx_en,
  output logic       fall_edge,
  output logic       trama_terminada,
  output logic [7:0] dout,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err
);

  rx_state_e   state_q, state_d;
  logic [3:0]  edge_cnt_q, edge_cnt_d;
  logic [9:0]  shreg_q, shreg_d;
  logic        cap_q, cap_d;
  logic [7:0]  dout_q, dout_d;
  logic [1:0]  d_sync_q, d_sync_d;
  logic        d_bit;
  logic        timeout;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk         (clk),
    .rst_n       (rst),
    .line_i      (ps2_c),
    .fall_edge_o (fall_edge)
  );

  assign d_bit = d_sync_q[1];

`ifdef PS2_RX_TIMEOUT_EN
  logic [TO_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_d    = '0;
    timeout = 1'b0;
    if (state_q == ST_SHIFT && !fall_edge) begin
      if (wd_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic [TO_W-1:0] unused_to_limit;
  assign unused_to_limit = TO_W'(TIMEOUT_CYCLES);
  assign timeout         = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    edge_cnt_d      = edge_cnt_q;
    shreg_d         = shreg_q;
    cap_d           = cap_q;
    dout_d          = dout_q;
    d_sync_d        = {d_sync_q[0], ps2_d};
    trama_terminada = 1'b0;
    rx_done         = 1'b0;
    parity_err      = 1'b0;
    frame_err       = 1'b0;

    // Frame counter runs even with capture off so the Tx side sees its own frame end.
    if (fall_edge) begin
      if (edge_cnt_q == 4'(FRAME_EDGES - 1)) begin
        edge_cnt_d      = '0;
        trama_terminada = 1'b1;
      end else begin
        edge_cnt_d = edge_cnt_q + 4'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (fall_edge) begin
          state_d   = ST_SHIFT;
          cap_d     = rx_en & ~d_bit;
          frame_err = rx_en & d_bit;
        end
      end
      ST_SHIFT: begin
        if (fall_edge) begin
          shreg_d = {d_bit, shreg_q[9:1]};
          if (edge_cnt_q == 4'(FRAME_EDGES - 1)) begin
            state_d = ST_CHECK;
          end
        end else if (timeout) begin
          state_d    = ST_IDLE;
          edge_cnt_d = '0;
          frame_err  = cap_q;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (cap_q) begin
          if (!shreg_q[9]) begin
            frame_err = 1'b1;
          end else if (!parity_ok(shreg_q[8:0])) begin
            parity_err = 1'b1;
          end else begin
            rx_done = 1'b1;
            dout_d  = shreg_q[7:0];
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The new byte is visible in the same cycle as rx_done.
  assign dout = dout_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      edge_cnt_q <= '0;
      shreg_q    <= '0;
      cap_q      <= 1'b0;
      dout_q     <= 8'h00;
      d_sync_q   <= '1;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      shreg_q    <= shreg_d;
      cap_q      <= cap_d;
      dout_q     <= dout_d;
      d_sync_q   <= d_sync_d;
    end
  end

endmodule
